button_conditioner: RTL and testbench

- Front-end stage between the raw Go Board push-buttons and the up/down digit counter.
- Synchronizes and debounces SW1 (up) and SW3 (down).
- Emits single-cycle increment/decrement strobes, with optional auto-repeat while a button is held.
- Replaces the counter's free-running slow-clock sampling: the counter advances on UP_PULSE/DOWN_PULSE in the CLK domain.

---
 rtl/button_conditioner.sv | 156 +++++++++++++++
 tb/tb_button_conditioner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop sync, per-button debounce, and a press FSM
// that turns debounced presses into single-cycle up/down strobes with optional auto-repeat.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw_i,
  output logic lvl_d_o,
  output logic lvl_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (sync_q[1] == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == DW'(DEBOUNCE_CYCLES)) begin
      lvl_d = ~lvl_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  assign lvl_d_o = lvl_d;
  assign lvl_o   = lvl_q;
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW1,
  input  logic SW3,
  output logic UP_PULSE,
  output logic DOWN_PULSE,
  output logic UP_LEVEL,
  output logic DOWN_LEVEL
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

  logic [1:0] raw, lvl_d, lvl_q;

  assign raw = {SW3, SW1};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .raw_i  (raw[g]),
      .lvl_d_o(lvl_d[g]),
      .lvl_o  (lvl_q[g])
    );
  end

  state_t        state_q, state_d;
  logic          act_up_q, act_up_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          up_p_q, up_p_d, dn_p_q, dn_p_d;
  logic          act_lvl;

  // Pulses are registered alongside the level so a strobe lines up with the first cycle the level reads 1.
  always_comb begin
    state_d  = state_q;
    act_up_d = act_up_q;
    rcnt_d   = rcnt_q;
    up_p_d   = 1'b0;
    dn_p_d   = 1'b0;
    act_lvl  = act_up_q ? lvl_d[0] : lvl_d[1];
    case (state_q)
      IDLE: begin
        rcnt_d = '0;
        if (lvl_d[0] && !lvl_q[0]) begin
          up_p_d   = 1'b1;
          act_up_d = 1'b1;
          state_d  = (REPEAT_EN != 0) ? DELAY : LOCK;
        end else if (lvl_d[1] && !lvl_q[1]) begin
          dn_p_d   = 1'b1;
          act_up_d = 1'b0;
          state_d  = (REPEAT_EN != 0) ? DELAY : LOCK;
        end
      end
      DELAY, REPEAT: begin
        if (!act_lvl) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == ((state_q == DELAY) ? RW'(REPEAT_DELAY - 1)
                                                   : RW'(REPEAT_PERIOD - 1))) begin
          up_p_d  = act_up_q;
          dn_p_d  = ~act_up_q;
          rcnt_d  = '0;
          state_d = REPEAT;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      LOCK: begin
        if (!act_lvl) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      act_up_q <= 1'b1;
      rcnt_q   <= '0;
      up_p_q   <= 1'b0;
      dn_p_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_up_q <= act_up_d;
      rcnt_q   <= rcnt_d;
      up_p_q   <= up_p_d;
      dn_p_q   <= dn_p_d;
    end
  end

  assign UP_PULSE   = up_p_q;
  assign DOWN_PULSE = dn_p_q;
  assign UP_LEVEL   = lvl_q[0];
  assign DOWN_LEVEL = lvl_q[1];
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: timings logged by a negedge monitor are checked
// against hand-computed cycle numbers (debounce 4, delay 20, period 8).
module tb_button_conditioner;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic SW1 = 1'b0, SW3 = 1'b0, sw1b = 1'b0, sw3b = 1'b0;
  logic UP_PULSE, DOWN_PULSE, UP_LEVEL, DOWN_LEVEL;
  logic nr_up, nr_dn, nr_ul, nr_dl;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW1(SW1), .SW3(SW3),
    .UP_PULSE(UP_PULSE), .DOWN_PULSE(DOWN_PULSE), .UP_LEVEL(UP_LEVEL), .DOWN_LEVEL(DOWN_LEVEL)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut_norep (
    .CLK(CLK), .RST_N(RST_N), .SW1(sw1b), .SW3(sw3b),
    .UP_PULSE(nr_up), .DOWN_PULSE(nr_dn), .UP_LEVEL(nr_ul), .DOWN_LEVEL(nr_dl)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int up_q[$], dn_q[$], nr_up_q[$], nr_dn_q[$];
  int up_rise = -1, up_fall = -1, dn_rise = -1, dn_fall = -1, both_hi = 0;
  logic ul_p = 1'b0, dl_p = 1'b0;

  // Log the cycle number of the last rising edge for every pulse and level change.
  always @(negedge CLK) begin
    if (UP_PULSE)   up_q.push_back(cyc);
    if (DOWN_PULSE) dn_q.push_back(cyc);
    if (nr_up)      nr_up_q.push_back(cyc);
    if (nr_dn)      nr_dn_q.push_back(cyc);
    if (UP_PULSE && DOWN_PULSE) both_hi <= both_hi + 1;
    if (UP_LEVEL && !ul_p)   up_rise <= cyc;
    if (!UP_LEVEL && ul_p)   up_fall <= cyc;
    if (DOWN_LEVEL && !dl_p) dn_rise <= cyc;
    if (!DOWN_LEVEL && dl_p) dn_fall <= cyc;
    ul_p <= UP_LEVEL;
    dl_p <= DOWN_LEVEL;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic go(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clrq();
    up_q.delete(); dn_q.delete(); nr_up_q.delete(); nr_dn_q.delete();
  endtask

  int t0, t1, t2;
  int rep_off[7] = '{0, 20, 28, 36, 44, 52, 60};

  initial begin
    #3 RST_N = 1'b0;
    #4;
    chk("rst_up_pulse", int'(UP_PULSE), 0);
    chk("rst_dn_pulse", int'(DOWN_PULSE), 0);
    chk("rst_up_level", int'(UP_LEVEL), 0);
    chk("rst_dn_level", int'(DOWN_LEVEL), 0);
    go(3);
    RST_N = 1'b1;
    go(5);
    clrq();

    // clean press: level and pulse 6 edges after the first sampling edge
    t0 = cyc + 1; SW1 = 1'b1; go(10);
    t1 = cyc + 1; SW1 = 1'b0; go(12);
    chk("clean_npulse", up_q.size(), 1);
    chk("clean_pulse_t", qat(up_q, 0), t0 + 6);
    chk("clean_rise_t", up_rise, t0 + 6);
    chk("clean_fall_t", up_fall, t1 + 6);
    chk("clean_no_dn", dn_q.size(), 0);
    clrq();

    // bounce on SW3 with 1/2/3-cycle runs, then a stable press
    SW3 = 1'b1; go(1); SW3 = 1'b0; go(1);
    SW3 = 1'b1; go(2); SW3 = 1'b0; go(2);
    SW3 = 1'b1; go(3); SW3 = 1'b0; go(3);
    chk("bounce_quiet", dn_q.size(), 0);
    t0 = cyc + 1; SW3 = 1'b1; go(10);
    SW3 = 1'b0; go(12);
    chk("bounce_npulse", dn_q.size(), 1);
    chk("bounce_pulse_t", qat(dn_q, 0), t0 + 6);
    clrq();

    // auto-repeat: held 60 cycles past debounce
    t0 = cyc + 1; SW1 = 1'b1; go(66);
    SW1 = 1'b0; go(12);
    chk("rep_npulse", up_q.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("rep_pulse%0d_t", i), qat(up_q, i), t0 + 6 + rep_off[i]);
    clrq();

    // simultaneous press: UP wins, DOWN level still tracks
    t0 = cyc + 1; SW1 = 1'b1; SW3 = 1'b1; go(30);
    SW1 = 1'b0; SW3 = 1'b0; go(12);
    chk("simul_nup", up_q.size(), 3);
    chk("simul_up2_t", qat(up_q, 2), t0 + 34);
    chk("simul_ndn", dn_q.size(), 0);
    chk("simul_dnlvl_rise", dn_rise, t0 + 6);
    clrq();

    // hand-off: SW3 held across SW1 release gives nothing until re-pressed
    SW1 = 1'b1; go(8);
    SW3 = 1'b1; go(8);
    SW1 = 1'b0; go(12);
    chk("handoff_dnlvl", int'(DOWN_LEVEL), 1);
    chk("handoff_ndn", dn_q.size(), 0);
    SW3 = 1'b0; go(10);
    t2 = cyc + 1; SW3 = 1'b1; go(10);
    SW3 = 1'b0; go(12);
    chk("handoff_nup", up_q.size(), 1);
    chk("repress_ndn", dn_q.size(), 1);
    chk("repress_dn_t", qat(dn_q, 0), t2 + 6);
    clrq();

    // async reset mid-REPEAT with SW1 held
    SW1 = 1'b1; go(40);
    chk("prerst_level", int'(UP_LEVEL), 1);
    RST_N = 1'b0;
    #1;
    chk("midrst_up_level", int'(UP_LEVEL), 0);
    chk("midrst_up_pulse", int'(UP_PULSE), 0);
    go(2);
    clrq();
    t0 = cyc + 1; RST_N = 1'b1; go(30);
    chk("postrst_npulse", up_q.size(), 2);
    chk("postrst_pulse_t", qat(up_q, 0), t0 + 6);
    chk("postrst_rep_t", qat(up_q, 1), t0 + 26);
    SW1 = 1'b0; go(12);
    clrq();

    // REPEAT_EN=0 instance: one pulse per press
    t0 = cyc + 1; sw1b = 1'b1; go(100);
    sw1b = 1'b0; go(12);
    chk("norep_npulse", nr_up_q.size(), 1);
    chk("norep_pulse_t", qat(nr_up_q, 0), t0 + 6);
    chk("norep_ndn", nr_dn_q.size(), 0);

    chk("mutex_both_hi", both_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
